// File: rtl/nn_layer_seq.sv
// Dense-layer sequencer: streams activations and weights into external memories, issues
// lane-wide MAC read cycles per neuron and writes each result back, one layer at a time.
module nn_layer_seq #(
  parameter int unsigned LANES      = 50,
  parameter int unsigned AW         = 16,
  parameter int unsigned CW         = 10,
  parameter int unsigned MAX_LAYERS = 4,
  parameter int unsigned RD_LAT     = 1,
  parameter int unsigned MAC_LAT    = 1,
  localparam int unsigned LW        = (MAX_LAYERS > 1) ? $clog2(MAX_LAYERS) : 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cfg_we,
  input  logic [LW-1:0] cfg_idx,
  input  logic [CW-1:0] cfg_chunks,
  input  logic [CW-1:0] cfg_neurons,
  input  logic [AW-1:0] cfg_in_base,
  input  logic [AW-1:0] cfg_out_base,
  input  logic [LW:0]   num_layers,
  input  logic          start,
  input  logic          abort,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          w_valid,
  output logic          w_ready,
  output logic          act_en,
  output logic          act_we,
  output logic [AW-1:0] act_addr,
  output logic          act_src_wb,
  output logic          wb_en,
  output logic          wb_we,
  output logic [AW-1:0] wb_addr,
  output logic          mac_clr,
  output logic          mac_en,
  output logic          mac_bias,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [LW-1:0] cur_layer,
  output logic [CW-1:0] cur_neuron
);

  localparam logic [AW-1:0] LaneStep  = AW'(LANES);
  localparam logic [CW-1:0] DrainLast = CW'(RD_LAT + MAC_LAT - 1);
  localparam logic [CW-1:0] CntOne    = CW'(1);

  typedef enum logic [2:0] {
    StIdle,
    StLoadIn,
    StLoadW,
    StMac,
    StBias,
    StDrain,
    StWb,
    StDone
  } state_e;

  state_e        state_q;
  logic [CW-1:0] k_q;
  logic [AW-1:0] off_q;
  logic [CW-1:0] n_q;
  logic [LW-1:0] layer_q;
  logic [LW:0]   nl_q;
  logic          err_q;

  logic [CW-1:0] chunks_q   [MAX_LAYERS];
  logic [CW-1:0] neurons_q  [MAX_LAYERS];
  logic [AW-1:0] in_base_q  [MAX_LAYERS];
  logic [AW-1:0] out_base_q [MAX_LAYERS];

  // {clr, en, bias} tags travel alongside the memory read latency.
  logic [2:0]    pipe_q [RD_LAT];
  logic [2:0]    issue;

  logic [CW-1:0] cur_chunks;
  logic [CW-1:0] cur_neurons;
  logic [AW-1:0] cur_in_base;
  logic [AW-1:0] cur_out_base;
  logic          abort_act;
  logic          cfg_bad;

  assign cur_chunks   = chunks_q[layer_q];
  assign cur_neurons  = neurons_q[layer_q];
  assign cur_in_base  = in_base_q[layer_q];
  assign cur_out_base = out_base_q[layer_q];
  assign abort_act    = abort && (state_q != StIdle);

  always_comb begin
    cfg_bad = (num_layers == '0) || (32'(num_layers) > MAX_LAYERS);
    for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
      if ((i < 32'(num_layers)) && ((chunks_q[i] == '0) || (neurons_q[i] == '0))) begin
        cfg_bad = 1'b1;
      end
    end
  end

  always_comb begin
    in_ready   = 1'b0;
    w_ready    = 1'b0;
    act_en     = 1'b0;
    act_we     = 1'b0;
    act_src_wb = 1'b0;
    act_addr   = '0;
    wb_en      = 1'b0;
    wb_we      = 1'b0;
    wb_addr    = '0;
    issue      = 3'b000;
    if (!abort_act) begin
      unique case (state_q)
        StLoadIn: begin
          in_ready = 1'b1;
          if (in_valid) begin
            act_en   = 1'b1;
            act_we   = 1'b1;
            act_addr = cur_in_base + off_q;
          end
        end
        StLoadW: begin
          w_ready = 1'b1;
          if (w_valid) begin
            wb_en   = 1'b1;
            wb_we   = 1'b1;
            wb_addr = off_q;
          end
        end
        StMac: begin
          act_en   = 1'b1;
          wb_en    = 1'b1;
          act_addr = cur_in_base + off_q;
          wb_addr  = off_q;
          issue    = {(k_q == '0), 1'b1, 1'b0};
        end
        StBias: begin
          wb_en   = 1'b1;
          wb_addr = off_q;
          issue   = 3'b001;
        end
        StWb: begin
          act_en     = 1'b1;
          act_we     = 1'b1;
          act_src_wb = 1'b1;
          act_addr   = cur_out_base + AW'(n_q);
        end
        default: ;
      endcase
    end
  end

  assign {mac_clr, mac_en, mac_bias} = abort_act ? 3'b000 : pipe_q[RD_LAT-1];
  assign busy       = (state_q != StIdle);
  assign done       = (state_q == StDone) && !abort_act;
  assign err        = err_q;
  assign cur_layer  = layer_q;
  assign cur_neuron = n_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      k_q     <= '0;
      off_q   <= '0;
      n_q     <= '0;
      layer_q <= '0;
      nl_q    <= '0;
      err_q   <= 1'b0;
      for (int unsigned i = 0; i < MAX_LAYERS; i++) begin
        chunks_q[i]   <= '0;
        neurons_q[i]  <= '0;
        in_base_q[i]  <= '0;
        out_base_q[i] <= '0;
      end
      for (int unsigned i = 0; i < RD_LAT; i++) begin
        pipe_q[i] <= '0;
      end
    end else begin
      err_q     <= 1'b0;
      pipe_q[0] <= issue;
      for (int unsigned i = 1; i < RD_LAT; i++) begin
        pipe_q[i] <= abort_act ? 3'b000 : pipe_q[i-1];
      end

      if (state_q == StIdle) begin
        if (cfg_we && (32'(cfg_idx) < MAX_LAYERS)) begin
          chunks_q[cfg_idx]   <= cfg_chunks;
          neurons_q[cfg_idx]  <= cfg_neurons;
          in_base_q[cfg_idx]  <= cfg_in_base;
          out_base_q[cfg_idx] <= cfg_out_base;
        end
        if (start) begin
          if (cfg_bad) begin
            err_q <= 1'b1;
          end else begin
            nl_q    <= num_layers;
            layer_q <= '0;
            n_q     <= '0;
            k_q     <= '0;
            off_q   <= '0;
            state_q <= StLoadIn;
          end
        end
      end else if (abort) begin
        state_q <= StIdle;
        layer_q <= '0;
        n_q     <= '0;
        k_q     <= '0;
        off_q   <= '0;
      end else begin
        unique case (state_q)
          StLoadIn: begin
            if (in_valid) begin
              if (k_q == cur_chunks - CntOne) begin
                k_q     <= '0;
                off_q   <= '0;
                state_q <= StLoadW;
              end else begin
                k_q   <= k_q + CntOne;
                off_q <= off_q + LaneStep;
              end
            end
          end
          StLoadW: begin
            // The beat after the last weight chunk carries the bias.
            if (w_valid) begin
              if (k_q == cur_chunks) begin
                k_q     <= '0;
                off_q   <= '0;
                state_q <= StMac;
              end else begin
                k_q   <= k_q + CntOne;
                off_q <= off_q + LaneStep;
              end
            end
          end
          StMac: begin
            off_q <= off_q + LaneStep;
            if (k_q == cur_chunks - CntOne) begin
              k_q     <= '0;
              state_q <= StBias;
            end else begin
              k_q <= k_q + CntOne;
            end
          end
          StBias: begin
            k_q     <= '0;
            off_q   <= '0;
            state_q <= StDrain;
          end
          StDrain: begin
            if (k_q == DrainLast) begin
              k_q     <= '0;
              state_q <= StWb;
            end else begin
              k_q <= k_q + CntOne;
            end
          end
          StWb: begin
            if (n_q + CntOne < cur_neurons) begin
              n_q     <= n_q + CntOne;
              state_q <= StLoadW;
            end else if ((LW+1)'(layer_q) + (LW+1)'(1) < nl_q) begin
              layer_q <= layer_q + LW'(1);
              n_q     <= '0;
              state_q <= StLoadW;
            end else begin
              state_q <= StDone;
            end
          end
          StDone: begin
            layer_q <= '0;
            n_q     <= '0;
            state_q <= StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nn_layer_seq.sv
// Bench for nn_layer_seq: cycle table for the single-layer case, model-checked memory traces
// for multi-layer, gapped and random runs, plus error, abort and async-reset sequences.
module tb_nn_layer_seq;
  localparam int LANES = 50;
  localparam int LW    = 2;

  localparam logic [2:0] KIN = 3'd1, KW = 3'd2, KMAC = 3'd3, KBIAS = 3'd4, KWB = 3'd5,
                         KBAD = 3'd7;

  logic          clk = 1'b0;
  logic          reset;
  logic          cfg_we;
  logic [LW-1:0] cfg_idx;
  logic [9:0]    cfg_chunks, cfg_neurons;
  logic [15:0]   cfg_in_base, cfg_out_base;
  logic [LW:0]   num_layers;
  logic          start, abort, in_valid, w_valid;
  logic          in_ready, w_ready, act_en, act_we, act_src_wb, wb_en, wb_we;
  logic [15:0]   act_addr, wb_addr;
  logic          mac_clr, mac_en, mac_bias, busy, done, err;
  logic [LW-1:0] cur_layer;
  logic [9:0]    cur_neuron;

  nn_layer_seq dut (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_chunks(cfg_chunks),
    .cfg_neurons(cfg_neurons), .cfg_in_base(cfg_in_base), .cfg_out_base(cfg_out_base),
    .num_layers(num_layers), .start(start), .abort(abort), .in_valid(in_valid),
    .in_ready(in_ready), .w_valid(w_valid), .w_ready(w_ready), .act_en(act_en),
    .act_we(act_we), .act_addr(act_addr), .act_src_wb(act_src_wb), .wb_en(wb_en),
    .wb_we(wb_we), .wb_addr(wb_addr), .mac_clr(mac_clr), .mac_en(mac_en),
    .mac_bias(mac_bias), .busy(busy), .done(done), .err(err), .cur_layer(cur_layer),
    .cur_neuron(cur_neuron)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  function automatic void check(string name, logic [63:0] got, logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Cycle-table observation record.
  typedef struct packed {
    logic        act_en, act_we, src;
    logic [15:0] act_addr;
    logic        wb_en, wb_we;
    logic [15:0] wb_addr;
    logic        clr, en, bias, done, busy;
  } obs_t;

  typedef struct {
    logic iv, wv;
    obs_t exp;
  } row_t;

  row_t tbl [1:13];

  function automatic obs_t mk(int ae, int awe, int src, int aa, int we, int wwe, int wa,
                              int clr, int en, int bias, int dn, int bsy);
    obs_t o;
    o.act_en = ae[0]; o.act_we = awe[0]; o.src = src[0]; o.act_addr = 16'(aa);
    o.wb_en = we[0]; o.wb_we = wwe[0]; o.wb_addr = 16'(wa);
    o.clr = clr[0]; o.en = en[0]; o.bias = bias[0]; o.done = dn[0]; o.busy = bsy[0];
    return o;
  endfunction

  function automatic obs_t observe();
    obs_t o;
    o.act_en = act_en; o.act_we = act_we; o.src = act_src_wb; o.act_addr = act_addr;
    o.wb_en = wb_en; o.wb_we = wb_we; o.wb_addr = wb_addr;
    o.clr = mac_clr; o.en = mac_en; o.bias = mac_bias; o.done = done; o.busy = busy;
    return o;
  endfunction

  function automatic logic [63:0] all_outputs();
    return 64'({act_addr, wb_addr, cur_layer, cur_neuron, in_ready, w_ready, act_en, act_we,
                act_src_wb, wb_en, wb_we, mac_clr, mac_en, mac_bias, busy, done, err});
  endfunction

  // Reference model: expected memory-operation trace derived from the layer configuration.
  typedef struct packed {
    logic [2:0]  kind;
    logic [15:0] a;
    logic [15:0] b;
  } ev_t;

  ev_t exp_q [$];
  int  m_ch [4], m_nr [4], m_in [4], m_out [4];
  int  m_nl;
  int  exp_clr, exp_en;

  function automatic void push(logic [2:0] kind, int a, int b);
    ev_t e;
    e.kind = kind; e.a = 16'(a); e.b = 16'(b);
    exp_q.push_back(e);
  endfunction

  function automatic void build_model();
    exp_q.delete();
    exp_clr = 0;
    exp_en  = 0;
    for (int k = 0; k < m_ch[0]; k++) push(KIN, m_in[0] + LANES * k, 0);
    for (int l = 0; l < m_nl; l++) begin
      for (int n = 0; n < m_nr[l]; n++) begin
        for (int j = 0; j <= m_ch[l]; j++) push(KW, LANES * j, 0);
        for (int k = 0; k < m_ch[l]; k++) push(KMAC, m_in[l] + LANES * k, LANES * k);
        push(KBIAS, LANES * m_ch[l], 0);
        push(KWB, m_out[l] + n, l * 1024 + n);
        exp_clr++;
        exp_en += m_ch[l];
      end
    end
  endfunction

  // Trace monitor: every strobe cycle is classified and matched against the model.
  logic mon_on = 1'b0;
  logic done_seen;
  int   done_cnt, err_cnt, clr_cnt, en_cnt, bias_cnt;
  ev_t  mon_ev;
  logic mon_has;

  always @(negedge clk) begin
    if (mon_on) begin
      mon_has = 1'b1;
      mon_ev  = '0;
      if (act_en && act_we && !act_src_wb) begin
        mon_ev.kind = KIN; mon_ev.a = act_addr;
        check("stall_in", 64'(in_valid), 64'd1);
      end else if (act_en && act_we && act_src_wb) begin
        mon_ev.kind = KWB; mon_ev.a = act_addr; mon_ev.b = {4'b0, cur_layer, cur_neuron};
      end else if (wb_en && wb_we) begin
        mon_ev.kind = KW; mon_ev.a = wb_addr;
        check("stall_w", 64'(w_valid), 64'd1);
      end else if (act_en && wb_en) begin
        mon_ev.kind = KMAC; mon_ev.a = act_addr; mon_ev.b = wb_addr;
      end else if (wb_en) begin
        mon_ev.kind = KBIAS; mon_ev.a = wb_addr;
      end else if (act_en) begin
        mon_ev.kind = KBAD; mon_ev.a = act_addr;
      end else begin
        mon_has = 1'b0;
      end
      if (mon_has) begin
        if (exp_q.size() == 0) check("extra_strobe", 64'(mon_ev), 64'd0);
        else check("mem_seq", 64'(mon_ev), 64'(exp_q.pop_front()));
      end
      clr_cnt  += int'(mac_clr);
      en_cnt   += int'(mac_en);
      bias_cnt += int'(mac_bias);
      err_cnt  += int'(err);
      if (done) begin
        done_cnt++;
        done_seen = 1'b1;
      end
    end
  end

  task automatic set_cfg(input int i, input int ch, input int nr, input int ib, input int ob);
    @(posedge clk); #1;
    cfg_we = 1'b1; cfg_idx = LW'(i); cfg_chunks = 10'(ch); cfg_neurons = 10'(nr);
    cfg_in_base = 16'(ib); cfg_out_base = 16'(ob);
    @(posedge clk); #1;
    cfg_we = 1'b0;
    m_ch[i] = ch; m_nr[i] = nr; m_in[i] = ib; m_out[i] = ob;
  endtask

  task automatic run_job(input int ipct, input int wpct, input bit perturb, input string name);
    int cyc;
    build_model();
    done_seen = 1'b0;
    done_cnt = 0; err_cnt = 0; clr_cnt = 0; en_cnt = 0; bias_cnt = 0;
    mon_on = 1'b1;
    @(posedge clk); #1;
    start = 1'b1;
    num_layers = (LW+1)'(m_nl);
    cyc = 0;
    while (!done_seen && cyc < 20000) begin
      @(posedge clk); #1;
      start    = 1'b0;
      in_valid = (int'($urandom_range(99)) < ipct);
      w_valid  = (int'($urandom_range(99)) < wpct);
      if (perturb && cyc == 20) begin
        cfg_we = 1'b1; cfg_idx = '0; cfg_chunks = '0; cfg_neurons = '0;
        start = 1'b1; num_layers = '0;
      end
      if (perturb && cyc == 21) cfg_we = 1'b0;
      cyc++;
    end
    in_valid = 1'b0; w_valid = 1'b0; cfg_we = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
    mon_on = 1'b0;
    check({name, "_done_seen"}, 64'(done_seen), 64'd1);
    check({name, "_done_cnt"}, 64'(done_cnt), 64'd1);
    check({name, "_trace_left"}, 64'(exp_q.size()), 64'd0);
    check({name, "_mac_clr"}, 64'(clr_cnt), 64'(exp_clr));
    check({name, "_mac_en"}, 64'(en_cnt), 64'(exp_en));
    check({name, "_mac_bias"}, 64'(bias_cnt), 64'(exp_clr));
    check({name, "_no_err"}, 64'(err_cnt), 64'd0);
    check({name, "_idle"}, 64'(busy), 64'd0);
  endtask

  task automatic run_table(input string name);
    @(posedge clk); #1;
    start = 1'b1;
    num_layers = 3'd1;
    for (int c = 1; c <= 13; c++) begin
      @(posedge clk); #1;
      start = 1'b0; in_valid = tbl[c].iv; w_valid = tbl[c].wv;
      @(negedge clk);
      check($sformatf("%s_cycle%0d", name, c), 64'(observe()), 64'(tbl[c].exp));
    end
    in_valid = 1'b0; w_valid = 1'b0;
  endtask

  task automatic expect_err(input int nl, input string name);
    @(posedge clk); #1;
    start = 1'b1; num_layers = (LW+1)'(nl);
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    check({name, "_err"}, 64'({err, busy, act_en, wb_en}), 64'b1000);
    @(negedge clk);
    check({name, "_after"}, 64'({err, busy, act_en, wb_en}), 64'b0000);
  endtask

  // Starts the single-layer case and returns right after the start-sampling edge.
  task automatic kick_single();
    @(posedge clk); #1;
    start = 1'b1; num_layers = 3'd1;
    @(posedge clk); #1;
    start = 1'b0; in_valid = 1'b1; w_valid = 1'b1;
  endtask

  int quiet;

  initial begin
    for (int c = 1; c <= 13; c++) begin
      tbl[c].iv = 1'b1;
      tbl[c].wv = 1'b1;
    end
    //                  ae awe src aa  we wwe wa   clr en bias dn busy
    tbl[1].exp  = mk(1, 1, 0, 0,   0, 0, 0,   0, 0, 0, 0, 1);
    tbl[2].exp  = mk(1, 1, 0, 50,  0, 0, 0,   0, 0, 0, 0, 1);
    tbl[3].exp  = mk(0, 0, 0, 0,   1, 1, 0,   0, 0, 0, 0, 1);
    tbl[4].exp  = mk(0, 0, 0, 0,   1, 1, 50,  0, 0, 0, 0, 1);
    tbl[5].exp  = mk(0, 0, 0, 0,   1, 1, 100, 0, 0, 0, 0, 1);
    tbl[6].exp  = mk(1, 0, 0, 0,   1, 0, 0,   0, 0, 0, 0, 1);
    tbl[7].exp  = mk(1, 0, 0, 50,  1, 0, 50,  1, 1, 0, 0, 1);
    tbl[8].exp  = mk(0, 0, 0, 0,   1, 0, 100, 0, 1, 0, 0, 1);
    tbl[9].exp  = mk(0, 0, 0, 0,   0, 0, 0,   0, 0, 1, 0, 1);
    tbl[10].exp = mk(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 1);
    tbl[11].exp = mk(1, 1, 1, 100, 0, 0, 0,   0, 0, 0, 0, 1);
    tbl[12].exp = mk(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 1, 1);
    tbl[13].exp = mk(0, 0, 0, 0,   0, 0, 0,   0, 0, 0, 0, 0);

    reset = 1'b0; cfg_we = 1'b0; cfg_idx = '0; cfg_chunks = '0; cfg_neurons = '0;
    cfg_in_base = '0; cfg_out_base = '0; num_layers = '0; start = 1'b0; abort = 1'b0;
    in_valid = 1'b0; w_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      m_ch[i] = 0; m_nr[i] = 0; m_in[i] = 0; m_out[i] = 0;
    end
    repeat (2) @(negedge clk);
    check("reset_outputs", all_outputs(), 64'd0);
    reset = 1'b1;
    @(negedge clk);
    check("post_reset_outputs", all_outputs(), 64'd0);

    // Cleared config entries must be rejected.
    expect_err(1, "cfg_reset_zero");

    set_cfg(0, 2, 1, 0, 100);
    m_nl = 1;
    run_table("single");

    set_cfg(0, 20, 100, 0, 1001);
    set_cfg(1, 2, 2, 1001, 0);
    m_nl = 2;
    run_job(100, 100, 1'b0, "two_layer");
    run_job(100, 50, 1'b0, "two_layer_wgap");
    run_job(50, 50, 1'b0, "two_layer_allgap");

    set_cfg(0, 3, 4, 10, 500);
    set_cfg(1, 2, 3, 500, 700);
    m_nl = 2;
    run_job(100, 100, 1'b1, "perturbed");
    run_job(100, 100, 1'b0, "unperturbed");

    for (int r = 0; r < 4; r++) begin
      m_nl = int'($urandom_range(4, 1));
      for (int i = 0; i < m_nl; i++) begin
        set_cfg(i, int'($urandom_range(4, 1)), int'($urandom_range(6, 1)),
                int'($urandom_range(65535)), int'($urandom_range(65535)));
      end
      run_job(int'($urandom_range(100, 40)), int'($urandom_range(100, 40)), 1'b0,
              $sformatf("random%0d", r));
    end

    expect_err(0, "nl_zero");
    expect_err(5, "nl_too_big");
    set_cfg(0, 2, 1, 0, 100);
    set_cfg(1, 0, 5, 0, 0);
    expect_err(2, "chunks_zero");
    set_cfg(1, 3, 0, 0, 0);
    expect_err(2, "neurons_zero");

    // Abort in the first drain cycle: no writeback, no done.
    kick_single();
    repeat (8) @(negedge clk);
    check("pre_abort_bias", 64'({wb_en, wb_we, act_en}), 64'b100);
    @(posedge clk); #1;
    abort = 1'b1;
    @(negedge clk);
    check("abort_cycle_quiet",
          64'({in_ready, w_ready, act_en, act_we, wb_en, wb_we, mac_clr, mac_en, mac_bias, done}),
          64'd0);
    @(posedge clk); #1;
    abort = 1'b0; in_valid = 1'b0; w_valid = 1'b0;
    @(negedge clk);
    check("abort_idle", 64'(busy), 64'd0);
    quiet = 0;
    repeat (6) begin
      @(negedge clk);
      quiet += int'(done) + int'(act_we) + int'(busy);
    end
    check("abort_no_wb_done", 64'(quiet), 64'd0);
    run_table("after_abort");

    // Asynchronous reset while issuing MAC reads.
    kick_single();
    repeat (6) @(negedge clk);
    check("pre_reset_mac", 64'({act_en, act_we, wb_en, wb_we}), 64'b1010);
    #1 reset = 1'b0;
    #1 check("async_reset_outputs", all_outputs(), 64'd0);
    in_valid = 1'b0; w_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("held_reset_outputs", all_outputs(), 64'd0);
    reset = 1'b1;
    set_cfg(0, 2, 1, 0, 100);
    run_table("after_reset");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
